// File: rtl/rvm_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rvm_mem_arbiter
//
// Purpose:
//   Shares one single-port on-chip RAM between two requesters that both use
//   the core memory protocol: port 0 is the rvm_core memory port, port 1 is
//   the debug / program-loader port. Requests are arbitrated round-robin,
//   range- and alignment-checked, and then sequenced through the RAM's
//   fixed-latency read pipeline. Only one transaction is in flight at a time,
//   and every transaction is followed by at least one IDLE cycle.
//
// Handshake (both ports):
//   The requester raises c_en with addr/w_en/b_en/wdata and holds all of them
//   stable while stall is high. The transaction completes in the cycle where
//   c_en=1 and stall=0; rdata and error are valid in that cycle only.
//   stall = c_en & ~done, so a port that is not requesting never sees stall.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   mN_addr/wdata/c_en/    requester N byte address, write data, request,
//   mN_w_en/b_en           write enable, byte enables (N = 0, 1)
//   mN_rdata/error/stall   requester N read data, access error, stall
//   ram_addr/wdata/c_en/   RAM word address, write data, enable,
//   ram_w_en/b_en          write enable, byte write enables
//   ram_rdata              RAM read data, RAM_LATENCY cycles after ram_c_en
//   dbg_state              current FSM state:
//                          0=IDLE 1=ACCESS 2=WAIT 3=DONE 4=ERROR
//   mN_wait_cnt            (only with RVM_MEM_ARB_WAIT_CNT_EN) saturating count
//                          of cycles in which port N was stalled
//
// Parameters:
//   ADDR_BITS    RAM word-address width; RAM size is 4 * 2^ADDR_BITS bytes
//                (at most 29 so that a tag field remains above the index).
//   RAM_LATENCY  cycles from ram_c_en to valid ram_rdata, 1..4.
//   BASE_ADDR    byte base of the RAM, aligned to the RAM size.
//
// Optional feature macro: RVM_MEM_ARB_WAIT_CNT_EN
// ---------------------------------------------------------------------------
module rvm_mem_arbiter #(
    parameter int          ADDR_BITS   = 12,
    parameter int          RAM_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          m0_addr,
    input  logic [31:0]          m0_wdata,
    input  logic                 m0_c_en,
    input  logic                 m0_w_en,
    input  logic [3:0]           m0_b_en,
    output logic [31:0]          m0_rdata,
    output logic                 m0_error,
    output logic                 m0_stall,
    input  logic [31:0]          m1_addr,
    input  logic [31:0]          m1_wdata,
    input  logic                 m1_c_en,
    input  logic                 m1_w_en,
    input  logic [3:0]           m1_b_en,
    output logic [31:0]          m1_rdata,
    output logic                 m1_error,
    output logic                 m1_stall,
`ifdef RVM_MEM_ARB_WAIT_CNT_EN
    output logic [31:0]          m0_wait_cnt,
    output logic [31:0]          m1_wait_cnt,
`endif
    output logic [2:0]           dbg_state,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [31:0]          ram_wdata,
    output logic                 ram_c_en,
    output logic                 ram_w_en,
    output logic [3:0]           ram_b_en,
    input  logic [31:0]          ram_rdata
);

    // Lowest address bit that must match BASE_ADDR for an in-range access.
    localparam int TAG_LSB = ADDR_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;          // port owning the current transaction
    logic        last_grant_q, last_grant_d;
    logic [2:0]  cnt_q, cnt_d;              // read-latency countdown
    logic [31:0] rdata_q, rdata_d;

    logic        sel_port;
    logic        done0;
    logic        done1;

    function automatic logic is_illegal(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:TAG_LSB] != BASE_ADDR[31:TAG_LSB]);
    endfunction

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;   // port 0 wins the first conflict
            cnt_q        <= 3'd0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        sel_port     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (m0_c_en || m1_c_en) begin
                    if (m0_c_en && m1_c_en) begin
                        // Conflict: the port that did not win last time goes.
                        sel_port     = ~last_grant_q;
                        last_grant_d = ~last_grant_q;
                    end else begin
                        sel_port = m1_c_en;
                    end
                    grant_d = sel_port;
                    state_d = is_illegal(sel_port ? m1_addr : m0_addr) ? S_ERROR : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (grant_q ? m1_w_en : m0_w_en) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = 3'(RAM_LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Counter value 1 marks the cycle the RAM presents the data.
                if (cnt_q == 3'd1) begin
                    rdata_d = ram_rdata;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        ram_c_en  = 1'b0;
        ram_w_en  = 1'b0;
        ram_addr  = '0;
        ram_wdata = 32'd0;
        ram_b_en  = 4'd0;
        done0     = 1'b0;
        done1     = 1'b0;
        m0_error  = 1'b0;
        m1_error  = 1'b0;

        case (state_q)
            S_ACCESS: begin
                ram_c_en  = 1'b1;
                ram_w_en  = grant_q ? m1_w_en : m0_w_en;
                ram_addr  = grant_q ? m1_addr[ADDR_BITS+1:2] : m0_addr[ADDR_BITS+1:2];
                ram_wdata = grant_q ? m1_wdata : m0_wdata;
                ram_b_en  = grant_q ? m1_b_en : m0_b_en;
            end
            S_DONE: begin
                done0 = ~grant_q;
                done1 = grant_q;
            end
            S_ERROR: begin
                done0    = ~grant_q;
                done1    = grant_q;
                m0_error = ~grant_q;
                m1_error = grant_q;
            end
            default: ;
        endcase
    end

    // A port that already dropped c_en simply ignores its done pulse.
    assign m0_stall  = m0_c_en & ~done0;
    assign m1_stall  = m1_c_en & ~done1;
    assign m0_rdata  = rdata_q;
    assign m1_rdata  = rdata_q;
    assign dbg_state = state_q;

`ifdef RVM_MEM_ARB_WAIT_CNT_EN
    logic [31:0] m0_wait_cnt_q, m0_wait_cnt_d;
    logic [31:0] m1_wait_cnt_q, m1_wait_cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m0_wait_cnt_q <= 32'd0;
            m1_wait_cnt_q <= 32'd0;
        end else begin
            m0_wait_cnt_q <= m0_wait_cnt_d;
            m1_wait_cnt_q <= m1_wait_cnt_d;
        end
    end

    // Saturating stall-cycle counters.
    always_comb begin
        m0_wait_cnt_d = m0_wait_cnt_q;
        m1_wait_cnt_d = m1_wait_cnt_q;
        if (m0_c_en && m0_stall && (m0_wait_cnt_q != 32'hFFFF_FFFF)) begin
            m0_wait_cnt_d = m0_wait_cnt_q + 32'd1;
        end
        if (m1_c_en && m1_stall && (m1_wait_cnt_q != 32'hFFFF_FFFF)) begin
            m1_wait_cnt_d = m1_wait_cnt_q + 32'd1;
        end
    end

    assign m0_wait_cnt = m0_wait_cnt_q;
    assign m1_wait_cnt = m1_wait_cnt_q;
`endif

endmodule
